// File: rtl/modulo_controle_jogo.sv
// modulo_controle_jogo: debounces confirm/clear, syncs coordinates and runs placement -> attack -> end,
// writing the position/attack matrices and status codes read by the display path.
module modulo_controle_jogo #(
  parameter int N_LIN      = 7,
  parameter int N_COL      = 5,
  parameter int N_NAVIOS   = 5,
  parameter int DEB_CYCLES = 50000
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   btn_confirm_n,
  input  logic                   btn_clear_n,
  input  logic [5:0]             coord_in,
  output logic [N_LIN*N_COL-1:0] m_po,
  output logic [N_LIN*N_COL-1:0] m_at,
  output logic [1:0]             status,
  output logic [5:0]             coord_at,
  output logic [1:0]             fase,
  output logic [2:0]             acertos
);
  localparam int N_CEL = N_LIN * N_COL;
  localparam int IW = $clog2(N_CEL);
  localparam int CW = $clog2(N_CEL + 1);
  localparam int DW = DEB_CYCLES > 1 ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] NAV_C = CW'(N_NAVIOS);
  localparam logic [2:0] NAV_A = 3'(N_NAVIOS);
  typedef enum logic [1:0] {POSICIONA = 2'b00, ATAQUE = 2'b01, FIM = 2'b10} estado_t;
  logic [1:0]       r_btn_s1, r_btn_s2, r_lvl, r_press;
  logic [DW-1:0]    r_cnt [2];
  logic [5:0]       r_coord_s1, r_coord_s2;
  estado_t          r_estado;
  logic [N_CEL-1:0] r_m_po, r_m_at;
  logic [1:0]       r_status;
  logic [5:0]       r_coord_at;
  logic [2:0]       r_acertos;
  logic [CW-1:0]    r_placed;
  logic [2:0]       w_row, w_col;
  logic             w_valid, w_po_hit, w_at_hit, w_conf, w_clr;
  logic [IW-1:0]    w_idx;
  logic [N_CEL-1:0] w_bit;
  assign w_row    = r_coord_s2[5:3];
  assign w_col    = r_coord_s2[2:0];
  assign w_valid  = (int'(w_row) < N_LIN) && (int'(w_col) < N_COL);
  assign w_idx    = IW'(int'(w_row) * N_COL + int'(w_col));
  assign w_bit    = w_valid ? (N_CEL'(1) << w_idx) : '0;
  assign w_po_hit = |(r_m_po & w_bit);
  assign w_at_hit = |(r_m_at & w_bit);
  assign w_conf   = r_press[0];
  assign w_clr    = r_press[1];
  // Index 0 is confirm, 1 is clear; a pulse fires only on the released->pressed flip of the level.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_btn_s1   <= 2'b11;
      r_btn_s2   <= 2'b11;
      r_coord_s1 <= '0;
      r_coord_s2 <= '0;
      r_lvl      <= 2'b11;
      r_press    <= '0;
      for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
    end else begin
      r_btn_s1   <= {btn_clear_n, btn_confirm_n};
      r_btn_s2   <= r_btn_s1;
      r_coord_s1 <= coord_in;
      r_coord_s2 <= r_coord_s1;
      for (int i = 0; i < 2; i++) begin
        r_press[i] <= 1'b0;
        if (r_btn_s2[i] == r_lvl[i]) r_cnt[i] <= '0;
        else if (r_cnt[i] == DEB_MAX) begin
          r_cnt[i]   <= '0;
          r_lvl[i]   <= r_btn_s2[i];
          r_press[i] <= ~r_btn_s2[i];
        end else r_cnt[i] <= r_cnt[i] + DW'(1);
      end
    end
  end
  // Clear outranks a confirm landing in the same cycle.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_estado   <= POSICIONA;
      r_m_po     <= '0;
      r_m_at     <= '0;
      r_status   <= 2'b00;
      r_coord_at <= '0;
      r_acertos  <= '0;
      r_placed   <= '0;
    end else if (w_clr) begin
      r_estado   <= POSICIONA;
      r_m_po     <= '0;
      r_m_at     <= '0;
      r_status   <= 2'b00;
      r_coord_at <= '0;
      r_acertos  <= '0;
      r_placed   <= '0;
    end else if (w_conf && r_estado != FIM) begin
      r_coord_at <= r_coord_s2;
      if (!w_valid) r_status <= 2'b11;
      else if (r_estado == POSICIONA) begin
        if (w_po_hit) r_status <= 2'b11;
        else begin
          r_m_po   <= r_m_po | w_bit;
          r_status <= 2'b00;
          r_placed <= r_placed + CW'(1);
          if (r_placed + CW'(1) == NAV_C) r_estado <= ATAQUE;
        end
      end else if (w_at_hit) r_status <= 2'b11;
      else begin
        r_m_at <= r_m_at | w_bit;
        if (w_po_hit) begin
          r_status  <= 2'b10;
          r_acertos <= r_acertos + 3'd1;
          if (r_acertos + 3'd1 == NAV_A) r_estado <= FIM;
        end else r_status <= 2'b01;
      end
    end
  end
  assign m_po     = r_m_po;
  assign m_at     = r_m_at;
  assign status   = r_status;
  assign coord_at = r_coord_at;
  assign fase     = r_estado;
  assign acertos  = r_acertos;
endmodule
